// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD show arbiter: word layout, RGB565 colours,
// and the arbiter state encoding.
package lcd_pkg;

  localparam int LCD_WORD_W = 9;
  localparam int LCD_DC_BIT = 8;

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // The DC flag sits above the data byte in every writer word.
  function automatic logic [LCD_WORD_W-1:0] lcd_word(input logic dc, input logic [7:0] data_byte);
    return {dc, data_byte};
  endfunction

endpackage

// File: rtl/lcd_show_arbiter_if.sv
// Client-side and writer-side signals of the LCD show arbiter.
// The master modport is the arbiter, the slave modport is its environment.
interface lcd_show_arbiter_if #(parameter int N_CLI = 4);
  import lcd_pkg::*;

  logic [N_CLI-1:0]            cli_req;
  logic [N_CLI-1:0]            cli_en;
  logic [LCD_WORD_W*N_CLI-1:0] cli_data;
  logic [N_CLI-1:0]            cli_done;
  logic                        wr_done;

  logic [N_CLI-1:0]            cli_start;
  logic [N_CLI-1:0]            cli_wr_done;
  logic                        lcd_en;
  logic [LCD_WORD_W-1:0]       lcd_data;
  logic [N_CLI-1:0]            grant;
  logic                        busy;
  logic                        boot_done;
  logic                        err_timeout;

  modport master (
    input  cli_req, cli_en, cli_data, cli_done, wr_done,
    output cli_start, cli_wr_done, lcd_en, lcd_data, grant, busy, boot_done, err_timeout
  );

  modport slave (
    output cli_req, cli_en, cli_data, cli_done, wr_done,
    input  cli_start, cli_wr_done, lcd_en, lcd_data, grant, busy, boot_done, err_timeout
  );

endinterface

// File: rtl/lcd_rr_pick.sv
// Round-robin picker: first set bit of mask at or after rr_ptr, wrapping.
module lcd_rr_pick #(
  parameter int N = 4,
  localparam int G_W = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [G_W-1:0] rr_ptr,
  output logic           valid,
  output logic [G_W-1:0] idx
);

  int j;

  // Scanning from the farthest offset back lets the nearest hit overwrite.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (mask[G_W'(j)]) begin
        valid = 1'b1;
        idx   = G_W'(j);
      end
    end
  end

endmodule

// File: rtl/lcd_show_arbiter.sv
// Grants the shared LCD SPI writer to one show client at a time, boot client
// first, with a fixed idle gap between grants and a watchdog on hung clients.
module lcd_show_arbiter
  import lcd_pkg::*;
#(
  parameter int N_CLI       = 4,
  parameter int BOOT_CLI    = 0,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 2**22
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  lcd_show_arbiter_if.master  bus
);

  localparam int G_W    = $clog2(N_CLI);
  localparam int WDOG_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [N_CLI-1:0] BOOT_MASK = N_CLI'(1) << BOOT_CLI;

  arb_state_t         state;
  logic [G_W-1:0]     g;
  logic [G_W-1:0]     rr_ptr;
  logic [N_CLI-1:0]   pending;
  logic [WDOG_W-1:0]  wdog;
  logic [3:0]         gap_cnt;

  logic [N_CLI-1:0]   eligible;
  logic               pick_valid;
  logic [G_W-1:0]     pick_idx;
  logic [N_CLI-1:0]   pick_oh;
  logic [N_CLI-1:0]   g_oh;
  logic [G_W-1:0]     next_ptr;
  logic               done_g;
  logic               timeout_hit;
  logic [LCD_WORD_W-1:0] word_g;

  // Until the init client has finished, nobody else may touch the panel.
  assign eligible    = bus.boot_done ? pending : (pending & BOOT_MASK);
  assign pick_oh     = N_CLI'(1) << pick_idx;
  assign g_oh        = N_CLI'(1) << g;
  assign next_ptr    = (g == G_W'(N_CLI - 1)) ? '0 : g + G_W'(1);
  assign done_g      = |(bus.cli_done & g_oh);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wdog == WDOG_W'(1));

  lcd_rr_pick #(.N(N_CLI)) u_pick (
    .mask   (eligible),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      g               <= '0;
      rr_ptr          <= G_W'(BOOT_CLI);
      pending         <= BOOT_MASK;
      wdog            <= '0;
      gap_cnt         <= '0;
      bus.cli_start   <= '0;
      bus.grant       <= '0;
      bus.busy        <= 1'b0;
      bus.boot_done   <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      pending         <= pending | bus.cli_req;
      bus.cli_start   <= '0;
      bus.err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            g             <= pick_idx;
            bus.cli_start <= pick_oh;
            bus.grant     <= pick_oh;
            bus.busy      <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          // A fresh request from the grantee in this same cycle survives the clear.
          pending <= (pending & ~g_oh) | bus.cli_req;
          wdog    <= WDOG_W'(TIMEOUT_CYC);
          rr_ptr  <= next_ptr;
          state   <= RUN;
        end
        RUN: begin
          wdog <= wdog - WDOG_W'(1);
          if (done_g || timeout_hit) begin
            state     <= GAP;
            bus.grant <= '0;
            gap_cnt   <= '0;
            if (g == G_W'(BOOT_CLI)) bus.boot_done <= 1'b1;
            if (!done_g) bus.err_timeout <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYC - 1)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writer path is a pure mux off the registered owner so client timing is untouched.
  always_comb begin
    word_g = '0;
    for (int i = 0; i < N_CLI; i++) begin
      if (g == G_W'(i)) word_g = bus.cli_data[i*LCD_WORD_W +: LCD_WORD_W];
    end
    bus.lcd_en      = 1'b0;
    bus.lcd_data    = '0;
    bus.cli_wr_done = '0;
    if (state == RUN) begin
      bus.lcd_en      = |(bus.cli_en & g_oh);
      bus.lcd_data    = word_g;
      bus.cli_wr_done = bus.wr_done ? g_oh : '0;
    end
  end

endmodule

// File: tb/tb_lcd_show_arbiter.sv
// Scoreboard bench for lcd_show_arbiter: stimulus pushes expected starts,
// writes and aborts; a negedge monitor pops and compares them.
module tb_lcd_show_arbiter;
  import lcd_pkg::*;

  localparam int N   = 4;
  localparam int GAP_N = 4;
  localparam int TMO = 100;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  lcd_show_arbiter_if #(.N_CLI(N)) bus();

  lcd_show_arbiter #(
    .N_CLI(N), .BOOT_CLI(0), .GAP_CYC(GAP_N), .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [8:0] data;
    logic [3:0] wrd;
  } wr_exp_t;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_start_q[$];
  wr_exp_t    exp_wr_q[$];
  int         exp_err_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired, required event never seen at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Monitor: every start, write strobe and abort the DUT shows must match the queue head.
  logic [3:0] mon_start;
  wr_exp_t    mon_wr;
  int         mon_err;
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.cli_start != 4'b0000) begin
        if (exp_start_q.size() == 0) check_output("unexpected_start", 32'(bus.cli_start), 32'h0);
        else begin
          mon_start = exp_start_q.pop_front();
          check_output("start", 32'(bus.cli_start), 32'(mon_start));
          check_output("grant_at_start", 32'(bus.grant), 32'(mon_start));
        end
      end
      if (bus.wr_done) begin
        if (exp_wr_q.size() == 0) check_output("unexpected_write", 32'(bus.cli_wr_done), 32'h0);
        else begin
          mon_wr = exp_wr_q.pop_front();
          check_output("lcd_data", 32'(bus.lcd_data), 32'(mon_wr.data));
          check_output("cli_wr_done", 32'(bus.cli_wr_done), 32'(mon_wr.wrd));
          check_output("lcd_en", 32'(bus.lcd_en), 32'h1);
        end
      end
      if (bus.err_timeout) begin
        if (exp_err_q.size() == 0) check_output("unexpected_err", 32'(bus.err_timeout), 32'h0);
        else begin
          mon_err = exp_err_q.pop_front();
          check_output("err_busy", 32'(bus.busy), 32'h1);
          check_output("err_grant", 32'(bus.grant), 32'h0);
        end
      end
    end
  end

  task automatic wait_start(input int c, output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge sys_clk);
      if (bus.cli_start[c]) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
    if (!ok) fail_bound($sformatf("start_client%0d", c));
  endtask

  // Acts as client c for one grant: nwr writes starting at d0, then done.
  task automatic apply_stimulus(input int c, input int nwr, input logic [8:0] d0,
                                input bit noise, input bit rereq, output int lat);
    bit ok;
    int n;
    wr_exp_t w;
    wait_start(c, ok, lat);
    if (!ok) return;
    if (rereq) begin
      bus.cli_req[c] = 1'b1;
      exp_start_q.push_back(4'(1 << c));
    end
    tick();
    if (rereq) bus.cli_req = '0;
    for (int k = 0; k < nwr; k++) begin
      bus.cli_en[c] = 1'b1;
      bus.cli_data[c*9 +: 9] = 9'(d0 + 9'(k));
      if (noise) begin
        bus.cli_en[0]        = 1'b1;
        bus.cli_done[0]      = 1'b1;
        bus.cli_data[0 +: 9] = 9'h0AA;
      end
      w.data = 9'(d0 + 9'(k));
      w.wrd  = 4'(1 << c);
      exp_wr_q.push_back(w);
      bus.wr_done = 1'b1;
      tick();
      bus.wr_done = 1'b0;
      bus.cli_en  = '0;
      bus.cli_done = '0;
    end
    bus.cli_done[c] = 1'b1;
    tick();
    bus.cli_done[c] = 1'b0;
    @(negedge sys_clk);
    check_output("gap_grant", 32'(bus.grant), 32'h0);
    check_output("gap_lcd_en", 32'(bus.lcd_en), 32'h0);
    if (c == 0) check_output("boot_done", 32'(bus.boot_done), 32'h1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (!bus.busy) break;
      n++;
    end
    check_output($sformatf("gap_len_client%0d", c), 32'(n), 32'(GAP_N));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit ok;
    int lat;
    int cyc;
    bus.cli_req  = '0;
    bus.cli_en   = '0;
    bus.cli_data = '0;
    bus.cli_done = '0;
    bus.wr_done  = 1'b0;
    exp_start_q.push_back(4'b0001);

    repeat (2) @(negedge sys_clk);
    check_output("rst_cli_start", 32'(bus.cli_start), 32'h0);
    check_output("rst_grant", 32'(bus.grant), 32'h0);
    check_output("rst_busy", 32'(bus.busy), 32'h0);
    check_output("rst_boot_done", 32'(bus.boot_done), 32'h0);
    check_output("rst_err", 32'(bus.err_timeout), 32'h0);
    check_output("rst_lcd_en", 32'(bus.lcd_en), 32'h0);
    check_output("rst_lcd_data", 32'(bus.lcd_data), 32'h0);
    check_output("rst_cli_wr_done", 32'(bus.cli_wr_done), 32'h0);
    sys_rst_n = 1'b1;

    // Boot run with requests from 1..3 arriving mid-boot; they must wait.
    fork
      apply_stimulus(0, 3, 9'h111, 1'b0, 1'b0, lat);
      begin
        repeat (3) @(posedge sys_clk);
        #1;
        bus.cli_req = 4'b1110;
        exp_start_q.push_back(4'b0010);
        exp_start_q.push_back(4'b0100);
        exp_start_q.push_back(4'b1000);
        tick();
        bus.cli_req = '0;
      end
    join
    check_output("boot_latency", 32'(lat), 32'h1);

    apply_stimulus(1, 2, 9'h101, 1'b0, 1'b0, lat);
    apply_stimulus(2, 2, 9'h1F8, 1'b1, 1'b0, lat);

    // Client 3 hangs: watchdog fires on its 100th RUN cycle.
    exp_err_q.push_back(3);
    wait_start(3, ok, lat);
    if (ok) begin
      cyc = 0;
      for (int i = 1; i <= 300; i++) begin
        @(negedge sys_clk);
        if (bus.err_timeout) begin
          cyc = i;
          break;
        end
      end
      if (cyc == 0) fail_bound("err_timeout");
      else begin
        check_output("err_latency", 32'(cyc), 32'(TMO + 1));
        repeat (3) @(negedge sys_clk);
        check_output("abort_gap_busy", 32'(bus.busy), 32'h1);
        @(negedge sys_clk);
        check_output("abort_idle_busy", 32'(bus.busy), 32'h0);
      end
    end

    tick();
    bus.cli_req = 4'b0010;
    exp_start_q.push_back(4'b0010);
    tick();
    bus.cli_req = '0;
    apply_stimulus(1, 1, 9'h033, 1'b0, 1'b1, lat);
    apply_stimulus(1, 1, 9'h034, 1'b0, 1'b0, lat);

    // Reset while client 2 is mid-write.
    tick();
    bus.cli_req = 4'b0100;
    exp_start_q.push_back(4'b0100);
    tick();
    bus.cli_req = '0;
    wait_start(2, ok, lat);
    tick();
    bus.cli_en[2] = 1'b1;
    bus.cli_data[18 +: 9] = 9'h155;
    @(negedge sys_clk);
    check_output("run_lcd_en", 32'(bus.lcd_en), 32'h1);
    check_output("run_lcd_data", 32'(bus.lcd_data), 32'h155);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_output("async_lcd_en", 32'(bus.lcd_en), 32'h0);
    check_output("async_grant", 32'(bus.grant), 32'h0);
    check_output("async_busy", 32'(bus.busy), 32'h0);
    check_output("async_boot_done", 32'(bus.boot_done), 32'h0);
    bus.cli_en = '0;
    exp_start_q.push_back(4'b0001);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    apply_stimulus(0, 1, 9'h1AB, 1'b0, 1'b0, lat);
    check_output("reboot_latency", 32'(lat), 32'h1);

    repeat (5) @(negedge sys_clk);
    check_output("start_q_left", 32'(exp_start_q.size()), 32'h0);
    check_output("wr_q_left", 32'(exp_wr_q.size()), 32'h0);
    check_output("err_q_left", 32'(exp_err_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
